// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes and datapath mux/ALU control encodings.
package mips_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop plus R-type funct to the 3-bit alucontrol code.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with ready-handshaked shared memory.
// Optional bne support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic       retire
);

    logic [3:0] state, state_next;
    logic [1:0] aluop;
    logic       pcwrite, branch, is_bne;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

`ifdef MC_CONTROLLER_BNE_EN
    // Sense of the branch condition is captured while the opcode is decoded.
    always_ff @(posedge clk) begin
        if (reset)                  is_bne <= 1'b0;
        else if (state == S_DECODE) is_bne <= (op == OP_BNE);
    end
`else
    assign is_bne = 1'b0;
`endif

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       state_next = S_BRANCH;
`endif
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_ready;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        pcen = pcwrite | (branch & (zero ^ is_bne));

        // Suppress every side-effecting strobe while reset is held.
        if (reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            illegal_op = 1'b0;
            retire     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random instructions against
// a step-list reference model derived from per-instruction behaviour.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite;
    logic       alusrca, illegal_op, retire;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {K_IF, K_ID, K_ADR, K_RD, K_LWB, K_WR, K_EX, K_RWB, K_BR, K_AEX,
                      K_AWB, K_JMP} step_t;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .retire     (retire)
    );

    // {mem_req,memwrite,iord,irwrite,pcen,regdst,memtoreg,regwrite,alusrca,
    //  alusrcb,pcsrc,alucontrol,illegal_op,retire}
    function automatic logic [18:0] observed();
        return {mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol, illegal_op, retire};
    endfunction

    function automatic bit bne_legal();
`ifdef MC_CONTROLLER_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    function automatic int base_latency(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            6'b000101: return bne_legal() ? 3 : 2;
            default: return 2;
        endcase
    endfunction

    function automatic logic [18:0] ref_out(input step_t s, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic rdy);
        logic mreq, mw, io, irw, pce, rd, m2r, rw, sa, ill, ret;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {mreq, mw, io, irw, pce, rd, m2r, rw, sa, ill, ret} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        case (s)
            K_IF:  begin mreq = 1; sb = 2'b01; irw = rdy; pce = rdy; end
            K_ID:  begin
                sb = 2'b11;
                if (base_latency(o) == 2) begin ill = 1; ret = 1; end
            end
            K_ADR: begin sa = 1; sb = 2'b10; end
            K_RD:  begin mreq = 1; io = 1; end
            K_LWB: begin m2r = 1; rw = 1; ret = 1; end
            K_WR:  begin mreq = 1; io = 1; mw = 1; ret = rdy; end
            K_EX:  begin sa = 1; ac = ref_alu(f); end
            K_RWB: begin rd = 1; rw = 1; ret = 1; end
            K_BR:  begin
                sa = 1; ac = 3'b110; ps = 2'b01; ret = 1;
                pce = (o == 6'b000101) ? ~z : z;
            end
            K_AEX: begin sa = 1; sb = 2'b10; end
            K_AWB: begin rw = 1; ret = 1; end
            K_JMP: begin ps = 2'b10; pce = 1; ret = 1; end
            default: ;
        endcase
        return {mreq, mw, io, irw, pce, rd, m2r, rw, sa, sb, ps, ac, ill, ret};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; waits<0 randomizes mem_ready, otherwise the data
    // access sees exactly `waits` not-ready cycles. Non-memory cycles get random mem_ready.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int waits);
        step_t steps[$];
        int idx = 0, cycles = 0, nwait = 0, dwait = 0, rets = 0, lat = -1;
        bit is_mem;
        logic rdy;
        steps.push_back(K_IF);
        steps.push_back(K_ID);
        case (o)
            6'b100011: begin steps.push_back(K_ADR); steps.push_back(K_RD);
                             steps.push_back(K_LWB); end
            6'b101011: begin steps.push_back(K_ADR); steps.push_back(K_WR); end
            6'b000000: begin steps.push_back(K_EX); steps.push_back(K_RWB); end
            6'b000100: steps.push_back(K_BR);
            6'b001000: begin steps.push_back(K_AEX); steps.push_back(K_AWB); end
            6'b000010: steps.push_back(K_JMP);
            6'b000101: if (bne_legal()) steps.push_back(K_BR);
            default: ;
        endcase
        op = o; funct = f; zero = z;
        while (idx < steps.size()) begin
            is_mem = steps[idx] inside {K_IF, K_RD, K_WR};
            if (!is_mem || cycles > 60) rdy = (cycles > 60) ? 1'b1 : 1'($urandom_range(0, 1));
            else if (waits < 0)         rdy = 1'($urandom_range(0, 1));
            else if (steps[idx] == K_IF) rdy = 1'b1;
            else                         rdy = (dwait >= waits);
            mem_ready = rdy;
            #1;
            check($sformatf("op%b_step%0d", o, idx), observed(), ref_out(steps[idx], o, f, z, rdy));
            if (is_mem && !rdy) begin nwait++; dwait += (steps[idx] != K_IF) ? 1 : 0; end
            cycles++;
            if (retire === 1'b1) begin rets++; if (lat < 0) lat = cycles; end
            @(posedge clk);
            if (!is_mem || rdy) idx++;
            @(negedge clk);
        end
        vectors++;
        assert (lat === base_latency(o) + nwait) else begin
            miscompares++;
            $error("FAIL latency_op%b: observed %0d expected %0d", o, lat, base_latency(o) + nwait);
        end
        vectors++;
        assert (rets === 1) else begin
            miscompares++;
            $error("FAIL retire_count_op%b: observed %0d expected 1", o, rets);
        end
    endtask

    task automatic check_reset_quiet(input string tag);
        logic [6:0] obs;
        obs = {mem_req, memwrite, irwrite, pcen, regwrite, illegal_op, retire};
        vectors++;
        assert (obs === 7'b0) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected 0000000", tag, obs);
        end
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [6];
        logic [31:0] r;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
                6'b000101, 6'b111111, 6'b010101};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'b0;
        @(negedge clk);
        #1 check_reset_quiet("reset_cycle1");
        @(negedge clk);
        #1 check_reset_quiet("reset_cycle2");
        reset = 1'b0;

        // Directed cases
        run_instr(6'b100011, 6'b000000, 1'b0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 3);
        run_instr(6'b000100, 6'b000000, 1'b1, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0);
        run_instr(6'b000000, 6'b101010, 1'b0, 0);
        run_instr(6'b000000, 6'b110011, 1'b0, 0);
        run_instr(6'b001000, 6'b000000, 1'b0, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0);
        run_instr(6'b000101, 6'b000000, 1'b0, 0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 2);

        // Reset during a MEMRD stall aborts the load without any writeback
        op = 6'b100011;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) begin
            #1 check("memrd_stall", observed(), ref_out(K_RD, op, funct, zero, 1'b0));
            @(negedge clk);
        end
        reset = 1'b1; mem_ready = 1'b1;
        #1 check_reset_quiet("reset_in_memrd");
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, 1'b0, 1);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] o, f;
            r = $urandom;
            o = (r[3:0] < 4'd9) ? ops[r[3:0]] : r[9:4];
            f = (r[12:10] < 3'd6) ? fns[r[12:10]] : r[18:13];
            run_instr(o, f, r[20], (r[21]) ? -1 : int'(r[23:22]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
